// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl
//  Purpose  : Bus-attached interrupt controller. Synchronises NUM_SRC raw
//             sources and applies per-source mask, edge/level mode and
//             polarity. Pending bits are write-1-to-clear, can be set by
//             software, and can be acknowledged by index. Drives one
//             registered CPU irq plus the index of the lowest pending,
//             enabled source.
//  Ports    : clk_i      - system clock, rising edge
//             reset_ni   - asynchronous active-low reset
//             cs_i       - chip select
//             wen_i      - write enable
//             addr_i     - register select
//             din_i      - write data
//             dout_o     - read data (combinational)
//             src_i      - raw interrupt sources
//             irq_o      - registered interrupt request
//             irq_idx_o  - registered winning source index
//             irqs_o     - pend & mask (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
  parameter int WIDTH       = 32,
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               cs_i,
  input  logic               wen_i,
  input  logic [2:0]         addr_i,
  input  logic [WIDTH-1:0]   din_i,
  output logic [WIDTH-1:0]   dout_o,
  input  logic [NUM_SRC-1:0] src_i,
  output logic               irq_o,
  output logic [4:0]         irq_idx_o,
  output logic [NUM_SRC-1:0] irqs_o
);

  localparam logic [2:0] ADDR_PEND  = 3'd0;
  localparam logic [2:0] ADDR_MASK  = 3'd1;
  localparam logic [2:0] ADDR_MODE  = 3'd2;
  localparam logic [2:0] ADDR_POL   = 3'd3;
  localparam logic [2:0] ADDR_VECT  = 3'd4;
  localparam logic [2:0] ADDR_ACK   = 3'd5;
  localparam logic [2:0] ADDR_SWSET = 3'd6;
  localparam logic [2:0] ADDR_CTRL  = 3'd7;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] pol_q, pol_d;
  logic [NUM_SRC-1:0] latch_q, latch_d;
  logic               gen_q, gen_d;
  logic               irq_q, irq_d;
  logic [4:0]         irq_idx_q, irq_idx_d;

  logic               wr_en;
  logic [NUM_SRC-1:0] wdat;
  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] ack_hot;
  logic [NUM_SRC-1:0] set_bits;
  logic [NUM_SRC-1:0] clr_bits;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] active;
  logic [4:0]         win_idx;
  logic [WIDTH-1:0]   vect;

  // Only the low NUM_SRC bits (and a few control bits) of din are meaningful.
  logic unused_din;
  assign unused_din = ^din_i;

  assign wr_en = cs_i & wen_i;
  assign wdat  = din_i[NUM_SRC-1:0];
  assign s     = sync_q[SYNC_STAGES-1];

  // Edge detection uses the raw synchronised history, so flipping POL on a
  // steady input can never fabricate an edge.
  assign edge_det = (s & ~prev_q & ~pol_q) | (~s & prev_q & pol_q);

  // Level sources contribute their live (polarity-corrected) value; the
  // latch holds edge events and software sets for every source.
  assign pend   = (~mode_q & (s ^ pol_q)) | latch_q;
  assign active = pend & mask_q;
  assign irqs_o = active;

  always_comb begin
    win_idx = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) win_idx = 5'(i);
    end
  end

  always_comb begin
    vect           = '0;
    vect[WIDTH-1]  = |active;
    vect[4:0]      = win_idx;
  end

  always_comb begin
    ack_hot = '0;
    if (wr_en && addr_i == ADDR_ACK) begin
      // Indices at or above NUM_SRC match no bit and are dropped.
      for (int i = 0; i < NUM_SRC; i++) begin
        if (din_i[4:0] == 5'(i)) ack_hot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    mask_d   = mask_q;
    mode_d   = mode_q;
    pol_d    = pol_q;
    gen_d    = gen_q;
    set_bits = edge_det & mode_q;
    clr_bits = ack_hot;

    if (wr_en) begin
      case (addr_i)
        ADDR_PEND:  clr_bits = clr_bits | wdat;
        ADDR_MASK:  mask_d = wdat;
        ADDR_MODE: begin
          mode_d   = wdat;
          // Leaving edge mode discards any stale edge latch.
          clr_bits = clr_bits | (mode_q & ~wdat);
        end
        ADDR_POL:   pol_d = wdat;
        ADDR_SWSET: set_bits = set_bits | wdat;
        ADDR_CTRL:  gen_d = din_i[0];
        default: ;
      endcase
    end

    // Set has priority over a clear landing in the same cycle.
    latch_d   = (latch_q & ~clr_bits) | set_bits;
    irq_d     = gen_q & (|active);
    irq_idx_d = win_idx;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q    <= '0;
      prev_q    <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      pol_q     <= '0;
      latch_q   <= '0;
      gen_q     <= 1'b0;
      irq_q     <= 1'b0;
      irq_idx_q <= 5'd0;
    end else begin
      sync_q[0] <= src_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q    <= s;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      pol_q     <= pol_d;
      latch_q   <= latch_d;
      gen_q     <= gen_d;
      irq_q     <= irq_d;
      irq_idx_q <= irq_idx_d;
    end
  end

  always_comb begin
    dout_o = '0;
    case (addr_i)
      ADDR_PEND:  dout_o[NUM_SRC-1:0] = pend;
      ADDR_MASK:  dout_o[NUM_SRC-1:0] = mask_q;
      ADDR_MODE:  dout_o[NUM_SRC-1:0] = mode_q;
      ADDR_POL:   dout_o[NUM_SRC-1:0] = pol_q;
      ADDR_VECT:  dout_o = vect;
      ADDR_CTRL:  dout_o[0] = gen_q;
      default:    dout_o = '0;
    endcase
  end

  assign irq_o     = irq_q;
  assign irq_idx_o = irq_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_ctrl
//  Purpose  : Self-checking bench for irq_ctrl. Stimulus pushes expected
//             values onto a scoreboard queue and raises a sample strobe; a
//             monitor on the falling edge pops and compares against the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

  localparam int K_DOUT = 0;
  localparam int K_IRQ  = 1;
  localparam int K_IDX  = 2;
  localparam int K_IRQS = 3;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        wen;
  logic [2:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [7:0]  src;
  logic        irq;
  logic [4:0]  irq_idx;
  logic [7:0]  irqs;

  exp_t        sb[$];
  logic        do_sample;
  int          n_chk;
  int          n_fail;

  irq_ctrl #(.WIDTH(32), .NUM_SRC(8), .SYNC_STAGES(2)) dut (
    .clk_i     (clk),
    .reset_ni  (rst_n),
    .cs_i      (cs),
    .wen_i     (wen),
    .addr_i    (addr),
    .din_i     (din),
    .dout_o    (dout),
    .src_i     (src),
    .irq_o     (irq),
    .irq_idx_o (irq_idx),
    .irqs_o    (irqs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares every queued expectation when the strobe is up.
  exp_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk) begin
    if (do_sample) begin
      while (sb.size() > 0) begin
        m_e = sb.pop_front();
        case (m_e.kind)
          K_DOUT:  m_act = dout;
          K_IRQ:   m_act = {31'd0, irq};
          K_IDX:   m_act = {27'd0, irq_idx};
          default: m_act = {24'd0, irqs};
        endcase
        n_chk++;
        if (m_act !== m_e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", m_e.name, m_act, m_e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wen = 1'b1; addr = a; din = d;
    tick();
    cs = 1'b0; wen = 1'b0; din = '0;
  endtask

  task automatic push(input int k, input logic [31:0] e, input string nm);
    exp_t x;
    x.kind = k; x.exp = e; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic rd_set(input logic [2:0] a, input logic [31:0] e, input string nm);
    cs = 1'b1; wen = 1'b0; addr = a;
    push(K_DOUT, e, nm);
  endtask

  task automatic sample();
    do_sample = 1'b1;
    @(negedge clk);
    #1;
    do_sample = 1'b0;
    cs = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    rd_set(a, e, nm);
    sample();
  endtask

  task automatic chk_irq(input logic i, input logic [4:0] x, input string nm);
    push(K_IRQ, {31'd0, i}, {nm, "_irq"});
    push(K_IDX, {27'd0, x}, {nm, "_idx"});
  endtask

  initial begin
    n_chk = 0; n_fail = 0; do_sample = 1'b0;
    rst_n = 1'b0; cs = 1'b0; wen = 1'b0; addr = '0; din = '0; src = 8'hFF;

    // 1: reset with sources all high
    ticks(3);
    for (int i = 0; i < 8; i++) rd(3'(i), 32'h0, $sformatf("rst_reg%0d", i));
    chk_irq(1'b0, 5'd0, "rst");
    push(K_IRQS, 32'h0, "rst_irqs");
    sample();
    rst_n = 1'b1;
    ticks(4);
    push(K_IRQ, 32'h0, "post_rst_irq");
    push(K_IRQS, 32'h0, "post_rst_irqs");
    sample();
    src = 8'h00;
    ticks(4);

    // 2: edge on src[3], then ACK
    wr(3'd2, 32'hFF);
    wr(3'd1, 32'hFF);
    wr(3'd7, 32'h1);
    ticks(2);
    src = 8'h08; tick(); src = 8'h00; ticks(2);
    rd_set(3'd0, 32'h08, "edge_pend");
    push(K_IRQ, 32'h0, "edge_irq_early");
    sample();
    tick();
    chk_irq(1'b1, 5'd3, "edge");
    sample();
    wr(3'd5, 32'd3);
    rd_set(3'd0, 32'h0, "ack_pend");
    push(K_IRQ, 32'h1, "ack_irq_hold");
    sample();
    tick();
    push(K_IRQ, 32'h0, "ack_irq_drop");
    sample();

    // 3: simultaneous edges, priority and W1C
    src = 8'h24; tick(); src = 8'h00; ticks(2);
    rd(3'd0, 32'h24, "prio_pend");
    rd_set(3'd4, 32'h8000_0002, "prio_vect");
    chk_irq(1'b1, 5'd2, "prio");
    sample();
    wr(3'd0, 32'h04);
    tick();
    chk_irq(1'b1, 5'd5, "prio_w1c");
    sample();
    wr(3'd0, 32'h20);

    // 4: level source with inverted polarity
    wr(3'd2, 32'h00);
    wr(3'd3, 32'h02);
    wr(3'd1, 32'h02);
    tick();
    chk_irq(1'b1, 5'd1, "lvl");
    push(K_IRQS, 32'h02, "lvl_irqs");
    sample();
    wr(3'd0, 32'h02);
    tick();
    rd_set(3'd0, 32'h02, "lvl_w1c_pend");
    push(K_IRQ, 32'h1, "lvl_w1c_irq");
    sample();
    src = 8'h02;
    ticks(3);
    rd_set(3'd0, 32'h0, "lvl_off_pend");
    push(K_IRQ, 32'h0, "lvl_off_irq");
    push(K_IRQS, 32'h0, "lvl_off_irqs");
    sample();

    // 5: set/clear collision and SWSET
    src = 8'h00; ticks(3);
    wr(3'd3, 32'h00);
    wr(3'd2, 32'hFF);
    wr(3'd1, 32'hFF);
    ticks(2);
    rd(3'd0, 32'h0, "coll_clean");
    src = 8'h01; tick(); src = 8'h00; tick();
    wr(3'd0, 32'h01);
    rd(3'd0, 32'h01, "coll_pend");
    wr(3'd6, 32'h80);
    rd(3'd0, 32'h81, "swset_pend");
    tick();
    chk_irq(1'b1, 5'd0, "swset");
    sample();
    wr(3'd0, 32'hFF);
    rd(3'd0, 32'h0, "w1c_all");

    // 6: polarity toggle on steady input, global enable, misc boundaries
    src = 8'h10; ticks(4);
    rd(3'd0, 32'h10, "steady_pend");
    wr(3'd0, 32'h10);
    rd(3'd0, 32'h0, "steady_w1c");
    wr(3'd3, 32'hFF); ticks(2);
    rd(3'd0, 32'h0, "pol_flip1");
    wr(3'd3, 32'h00); ticks(2);
    rd(3'd0, 32'h0, "pol_flip0");
    wr(3'd6, 32'h40);
    tick();
    chk_irq(1'b1, 5'd6, "gen_on");
    sample();
    wr(3'd7, 32'h0);
    tick();
    rd_set(3'd0, 32'h40, "gen_off_pend");
    push(K_IRQ, 32'h0, "gen_off_irq");
    sample();
    rd(3'd7, 32'h0, "ctrl_rd");
    wr(3'd1, 32'hFFFF_FFFF);
    rd(3'd1, 32'hFF, "mask_wide");
    wr(3'd5, 32'd8);
    rd(3'd0, 32'h40, "ack_oob");
    rd(3'd5, 32'h0, "ack_rd");
    rd(3'd6, 32'h0, "swset_rd");
    wr(3'd2, 32'hBF);
    rd(3'd0, 32'h0, "mode_fall_clr");
    wr(3'd6, 32'h01);
    wr(3'd7, 32'h1);
    tick();
    chk_irq(1'b1, 5'd0, "pre_rst");
    sample();
    tick();
    rst_n = 1'b0;
    chk_irq(1'b0, 5'd0, "mid_rst");
    rd_set(3'd0, 32'h0, "mid_rst_pend");
    push(K_IRQS, 32'h0, "mid_rst_irqs");
    sample();
    rst_n = 1'b1;
    ticks(2);

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
